if_fetch_unit: RTL and testbench

Instruction-fetch stage controller that reads the program counter and drives the PC's `PCWrite` hold control. It latches the current PC, runs a req/ack handshake with a variable-latency instruction memory, and loads the IF/ID instruction register. It also handles ID-stage back-pressure and branch flushes. It sits between the PC register (negedge-updated) and the ID stage.

---
 rtl/if_fetch_unit.sv | 128 ++++++++++++
 tb/tb_if_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage controller: latches the PC, runs a req/ack fetch against a
// variable-latency instruction memory and loads the IF/ID register, with stall and flush handling.
module if_fetch_unit #(
    parameter int pc_size   = 18,
    parameter int data_size = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [pc_size-1:0]   pc,
    output logic                 PCWrite,
    output logic                 imem_req,
    output logic [pc_size-1:0]   imem_addr,
    input  logic                 imem_ack,
    input  logic [data_size-1:0] imem_rdata,
    input  logic                 ID_stall,
    input  logic                 flush,
    output logic [data_size-1:0] IR_out,
    output logic [pc_size-1:0]   PC_plus4_out,
    output logic                 IR_valid,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        START = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [pc_size-1:0] ADDR_STEP = pc_size'(4);

    state_t                 state;
    logic                   kill;
    logic [data_size-1:0]   buf_q;
    logic [pc_size-1:0]     buf_pc4;

    logic                   ack_seen;
    logic                   blocked;
    logic                   load_mem;
    logic                   load_buf;

    // Handshake: imem_req stays high with imem_addr frozen until a single-cycle
    // imem_ack completes the access; an ack seen while imem_req is low is ignored.
    assign imem_req  = (state == REQ);
    assign dbg_state = state;

    assign ack_seen = (state == REQ) && imem_ack;
    assign blocked  = IR_valid && ID_stall;
    assign load_mem = ack_seen && !kill && !flush && !blocked;
    assign load_buf = (state == HOLD) && !flush && !ID_stall;

    // The PC register updates on the falling edge, so this must settle within the cycle.
    always_comb begin
        PCWrite = 1'b1;
        if (rst) begin
            PCWrite = 1'b1;
        end else if (flush) begin
            PCWrite = 1'b0;
        end else if (load_mem || load_buf) begin
            PCWrite = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= START;
            imem_addr    <= '0;
            IR_out       <= '0;
            PC_plus4_out <= '0;
            IR_valid     <= 1'b0;
            kill         <= 1'b0;
            buf_q        <= '0;
            buf_pc4      <= '0;
        end else begin
            if (IR_valid && !ID_stall) begin
                IR_valid <= 1'b0;
            end
            if (flush) begin
                IR_valid <= 1'b0;
            end

            case (state)
                START: begin
                    imem_addr <= pc;
                    kill      <= 1'b0;
                    state     <= REQ;
                end

                REQ: begin
                    if (imem_ack) begin
                        if (flush || kill) begin
                            // Redirected fetch: drop the word and restart at the new PC.
                            kill      <= 1'b0;
                            imem_addr <= pc;
                        end else if (blocked) begin
                            buf_q   <= imem_rdata;
                            buf_pc4 <= imem_addr + ADDR_STEP;
                            state   <= HOLD;
                        end else begin
                            IR_out       <= imem_rdata;
                            PC_plus4_out <= imem_addr + ADDR_STEP;
                            IR_valid     <= 1'b1;
                            imem_addr    <= pc;
                        end
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end

                HOLD: begin
                    if (flush) begin
                        state <= START;
                    end else if (!ID_stall) begin
                        IR_out       <= buf_q;
                        PC_plus4_out <= buf_pc4;
                        IR_valid     <= 1'b1;
                        imem_addr    <= pc;
                        state        <= REQ;
                    end
                end

                default: begin
                    state <= START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run checked against
// an instruction-stream model (program order from the PC, redirected by flush).
module tb_if_fetch_unit;

    localparam int PW = 18;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pc = '0;
    logic          PCWrite;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          ID_stall = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] IR_out;
    logic [PW-1:0] PC_plus4_out;
    logic          IR_valid;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder state
    int            mem_lat   = 0;
    bit            stray_en  = 1'b0;
    bit            pend      = 1'b0;
    int            wait_left = 0;
    logic [PW-1:0] req_addr  = '0;
    logic [PW-1:0] tgt_r     = '0;
    bit            force_en  = 1'b0;
    logic [DW-1:0] force_word = '0;

    logic [PW-1:0] exp_q[$];

    if_fetch_unit #(.pc_size(PW), .data_size(DW)) dut (
        .clk(clk), .rst(rst), .pc(pc), .PCWrite(PCWrite),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ID_stall(ID_stall), .flush(flush),
        .IR_out(IR_out), .PC_plus4_out(PC_plus4_out), .IR_valid(IR_valid),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mem_word(input logic [PW-1:0] a);
        logic [DW-1:0] m;
        if (force_en) return force_word;
        m = {{(DW-PW){1'b0}}, a};
        return (m * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    // Drive one cycle's inputs shortly after the rising edge, then let outputs settle.
    task automatic drive_cycle(input logic stall, input logic fl, input logic [PW-1:0] tgt);
        @(posedge clk);
        #1;
        ID_stall = stall;
        flush    = fl;
        tgt_r    = tgt;
        if (imem_req) begin
            if (!pend) begin
                pend      = 1'b1;
                req_addr  = imem_addr;
                wait_left = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            end
            imem_ack   = (wait_left == 0);
            imem_rdata = imem_ack ? mem_word(req_addr) : DW'($urandom);
        end else begin
            imem_ack   = stray_en && ($urandom_range(0, 3) == 0);
            imem_rdata = DW'($urandom);
        end
        #1;
    endtask

    // Falling edge: the PC register model loads when PCWrite is low.
    task automatic end_cycle;
        @(negedge clk);
        if (!rst && !PCWrite) pc = flush ? tgt_r : pc + PW'(4);
        if (imem_req && pend) begin
            if (imem_ack) pend = 1'b0;
            else wait_left--;
        end else begin
            pend = 1'b0;
        end
    endtask

    task automatic do_reset(input logic [PW-1:0] start_pc);
        @(posedge clk);
        #1;
        rst = 1'b1; ID_stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        pc = start_pc; pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        end_cycle();
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        rst = 1'b1; pc = '0; flush = 1'b0; ID_stall = 1'b0; imem_ack = 1'b0; pend = 1'b0;
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h expected 0", imem_req); end
        n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", imem_addr); end
        n_checks++; if (IR_out !== '0) begin n_fail++; $display("FAIL reset_ir: got %0h expected 0", IR_out); end
        n_checks++; if (PC_plus4_out !== '0) begin n_fail++; $display("FAIL reset_pc4: got %0h expected 0", PC_plus4_out); end
        n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", IR_valid); end
        n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL reset_pcwrite: got %0h expected 1", PCWrite); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // A stray ack in the START cycle must be ignored.
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL start_req: got %0h expected 0", imem_req); end
        n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL start_pcwrite: got %0h expected 1", PCWrite); end
        end_cycle();
        mem_lat = 5;
        drive_cycle(1'b0, 1'b0, '0);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %0h expected 1", imem_req); end
        n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL first_addr: got %0h expected 0", imem_addr); end
        n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL stray_ack_valid: got %0h expected 0", IR_valid); end
        end_cycle();
    endtask

    task automatic test_zero_wait;
        logic [PW-1:0] a;
        mem_lat = 0;
        do_reset('0);
        for (int k = 0; k < 4; k++) begin
            a = PW'(4 * k);
            drive_cycle(1'b0, 1'b0, '0);
            n_checks++; if (imem_addr !== a) begin n_fail++; $display("FAIL zw_addr[%0d]: got %0h expected %0h", k, imem_addr, a); end
            n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL zw_pcwrite[%0d]: got %0h expected 0", k, PCWrite); end
            if (k > 0) begin
                n_checks++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d]: got %0h expected 1", k, IR_valid); end
                n_checks++; if (PC_plus4_out !== a) begin n_fail++; $display("FAIL zw_pc4[%0d]: got %0h expected %0h", k, PC_plus4_out, a); end
                n_checks++; if (IR_out !== mem_word(a - PW'(4))) begin n_fail++; $display("FAIL zw_ir[%0d]: got %0h expected %0h", k, IR_out, mem_word(a - PW'(4))); end
            end
            end_cycle();
        end
    endtask

    task automatic test_wait3;
        mem_lat = 3; force_en = 1'b1; force_word = 32'h8C220004;
        do_reset(18'h100);
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b0, 1'b0, '0);
            if (k < 3) begin
                n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL w3_pcwrite_wait[%0d]: got %0h expected 1", k, PCWrite); end
            end else if (k == 3) begin
                n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL w3_pcwrite_ack: got %0h expected 0", PCWrite); end
                n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL w3_valid_early: got %0h expected 0", IR_valid); end
            end else begin
                n_checks++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL w3_valid: got %0h expected 1", IR_valid); end
                n_checks++; if (IR_out !== 32'h8C220004) begin n_fail++; $display("FAIL w3_ir: got %0h expected 8c220004", IR_out); end
                n_checks++; if (PC_plus4_out !== 18'h104) begin n_fail++; $display("FAIL w3_pc4: got %0h expected 104", PC_plus4_out); end
                n_checks++; if (imem_addr !== 18'h104) begin n_fail++; $display("FAIL w3_next_addr: got %0h expected 104", imem_addr); end
            end
            end_cycle();
        end
        force_en = 1'b0;
    endtask

    task automatic test_stall;
        logic [1:0] s_req;
        s_req = '0;
        mem_lat = 1;
        do_reset('0);
        for (int k = 0; k < 10; k++) begin
            drive_cycle((k >= 2 && k <= 5), 1'b0, '0);
            if (k == 2) s_req = dbg_state;
            if (k == 3) begin
                n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL st_blocked_pcwrite: got %0h expected 1", PCWrite); end
            end
            if (k == 4 || k == 5) begin
                n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_hold_req[%0d]: got %0h expected 0", k, imem_req); end
                n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL st_hold_pcwrite[%0d]: got %0h expected 1", k, PCWrite); end
                n_checks++; if (IR_out !== mem_word('0)) begin n_fail++; $display("FAIL st_hold_ir[%0d]: got %0h expected %0h", k, IR_out, mem_word('0)); end
                n_checks++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL st_hold_valid[%0d]: got %0h expected 1", k, IR_valid); end
                n_checks++; if (dbg_state === s_req) begin n_fail++; $display("FAIL st_hold_state[%0d]: got %0h expected not %0h", k, dbg_state, s_req); end
            end
            if (k == 6) begin
                n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL st_release_pcwrite: got %0h expected 0", PCWrite); end
            end
            if (k == 7) begin
                n_checks++; if (IR_out !== mem_word(18'h4)) begin n_fail++; $display("FAIL st_buf_ir: got %0h expected %0h", IR_out, mem_word(18'h4)); end
                n_checks++; if (PC_plus4_out !== 18'h8) begin n_fail++; $display("FAIL st_buf_pc4: got %0h expected 8", PC_plus4_out); end
                n_checks++; if (imem_addr !== 18'h8) begin n_fail++; $display("FAIL st_next_addr: got %0h expected 8", imem_addr); end
                n_checks++; if (dbg_state !== s_req) begin n_fail++; $display("FAIL st_back_state: got %0h expected %0h", dbg_state, s_req); end
            end
            if (k == 8) begin
                n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL st_consumed_valid: got %0h expected 0", IR_valid); end
            end
            if (k == 9) begin
                n_checks++; if (IR_out !== mem_word(18'h8)) begin n_fail++; $display("FAIL st_after_ir: got %0h expected %0h", IR_out, mem_word(18'h8)); end
                n_checks++; if (PC_plus4_out !== 18'hC) begin n_fail++; $display("FAIL st_after_pc4: got %0h expected c", PC_plus4_out); end
            end
            end_cycle();
        end
    endtask

    task automatic test_flush_wait;
        mem_lat = 2;
        do_reset('0);
        for (int k = 0; k < 10; k++) begin
            drive_cycle((k == 3), (k == 3), 18'h200);
            if (k == 3) begin
                n_checks++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL fw_pre_valid: got %0h expected 1", IR_valid); end
                n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL fw_flush_pcwrite: got %0h expected 0", PCWrite); end
            end
            if (k >= 4 && k <= 7) begin
                n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL fw_pcwrite[%0d]: got %0h expected 1", k, PCWrite); end
                n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL fw_valid[%0d]: got %0h expected 0", k, IR_valid); end
            end
            if (k == 4) begin
                n_checks++; if (imem_addr !== 18'h4) begin n_fail++; $display("FAIL fw_stale_addr: got %0h expected 4", imem_addr); end
            end
            if (k == 6) begin
                n_checks++; if (imem_addr !== 18'h200) begin n_fail++; $display("FAIL fw_target_addr: got %0h expected 200", imem_addr); end
            end
            if (k == 8) begin
                n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL fw_target_ack: got %0h expected 0", PCWrite); end
            end
            if (k == 9) begin
                n_checks++; if (IR_out !== mem_word(18'h200)) begin n_fail++; $display("FAIL fw_ir: got %0h expected %0h", IR_out, mem_word(18'h200)); end
                n_checks++; if (PC_plus4_out !== 18'h204) begin n_fail++; $display("FAIL fw_pc4: got %0h expected 204", PC_plus4_out); end
            end
            end_cycle();
        end
    endtask

    task automatic test_flush_ack;
        mem_lat = 0;
        do_reset('0);
        for (int k = 0; k < 5; k++) begin
            drive_cycle((k == 3), (k == 1 || k == 3), (k == 1) ? 18'h300 : 18'h40);
            if (k == 1) begin
                n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL fa_pcwrite: got %0h expected 0", PCWrite); end
            end
            if (k == 2) begin
                n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL fa_valid: got %0h expected 0", IR_valid); end
                n_checks++; if (imem_addr !== 18'h300) begin n_fail++; $display("FAIL fa_addr: got %0h expected 300", imem_addr); end
            end
            if (k == 3) begin
                n_checks++; if (IR_out !== mem_word(18'h300)) begin n_fail++; $display("FAIL fa_ir: got %0h expected %0h", IR_out, mem_word(18'h300)); end
                n_checks++; if (PC_plus4_out !== 18'h304) begin n_fail++; $display("FAIL fa_pc4: got %0h expected 304", PC_plus4_out); end
            end
            if (k == 4) begin
                n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL fa_stall_valid: got %0h expected 0", IR_valid); end
                n_checks++; if (imem_addr !== 18'h40) begin n_fail++; $display("FAIL fa_stall_addr: got %0h expected 40", imem_addr); end
            end
            end_cycle();
        end
    endtask

    task automatic test_wrap;
        mem_lat = 0;
        do_reset(18'h3FFFC);
        drive_cycle(1'b0, 1'b0, '0);
        n_checks++; if (imem_addr !== 18'h3FFFC) begin n_fail++; $display("FAIL wr_addr: got %0h expected 3fffc", imem_addr); end
        end_cycle();
        drive_cycle(1'b0, 1'b0, '0);
        n_checks++; if (PC_plus4_out !== '0) begin n_fail++; $display("FAIL wr_pc4: got %0h expected 0", PC_plus4_out); end
        n_checks++; if (IR_out !== mem_word(18'h3FFFC)) begin n_fail++; $display("FAIL wr_ir: got %0h expected %0h", IR_out, mem_word(18'h3FFFC)); end
        n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL wr_next_addr: got %0h expected 0", imem_addr); end
        end_cycle();
    endtask

    task automatic test_reset_mid;
        mem_lat = 1;
        do_reset('0);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0, '0);
            if (k < 2) end_cycle();
        end
        n_checks++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_valid: got %0h expected 1", IR_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %0h expected 0", imem_req); end
        n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL rm_addr: got %0h expected 0", imem_addr); end
        n_checks++; if (IR_out !== '0) begin n_fail++; $display("FAIL rm_ir: got %0h expected 0", IR_out); end
        n_checks++; if (PC_plus4_out !== '0) begin n_fail++; $display("FAIL rm_pc4: got %0h expected 0", PC_plus4_out); end
        n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %0h expected 0", IR_valid); end
        n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL rm_pcwrite: got %0h expected 1", PCWrite); end
        end_cycle();
        ID_stall = 1'b0;
        do_reset(18'h80);
        drive_cycle(1'b0, 1'b0, '0);
        n_checks++; if (imem_addr !== 18'h80) begin n_fail++; $display("FAIL rm_restart_addr: got %0h expected 80", imem_addr); end
        end_cycle();
    endtask

    task automatic test_random;
        logic [PW-1:0] start;
        logic [PW-1:0] tgt;
        logic [PW-1:0] e;
        bit            was_pend;
        int            consumed;
        consumed = 0;
        mem_lat = -1; stray_en = 1'b1;
        start = PW'($urandom) & ~PW'(3);
        do_reset(start);
        exp_q.delete();
        exp_q.push_back(start);
        for (int c = 0; c < 3000; c++) begin
            tgt = PW'($urandom) & ~PW'(3);
            was_pend = pend;
            drive_cycle(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 4), tgt);
            if (was_pend && imem_req) begin
                n_checks++; if (imem_addr !== req_addr) begin n_fail++; $display("FAIL rnd_addr_stable[%0d]: got %0h expected %0h", c, imem_addr, req_addr); end
            end
            if (IR_valid && !ID_stall) begin
                e = exp_q.pop_front();
                consumed++;
                n_checks++; if (IR_out !== mem_word(e)) begin n_fail++; $display("FAIL rnd_ir[%0d]: got %0h expected %0h (addr %0h)", c, IR_out, mem_word(e), e); end
                n_checks++; if (PC_plus4_out !== e + PW'(4)) begin n_fail++; $display("FAIL rnd_pc4[%0d]: got %0h expected %0h", c, PC_plus4_out, e + PW'(4)); end
                if (exp_q.size() == 0) exp_q.push_back(e + PW'(4));
            end
            if (flush) begin
                exp_q.delete();
                exp_q.push_back(tgt);
            end
            end_cycle();
        end
        n_checks++; if (consumed < 300) begin n_fail++; $display("FAIL rnd_throughput: got %0d instructions expected at least 300", consumed); end
        stray_en = 1'b0;
        ID_stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait3();
        test_stall();
        test_flush_wait();
        test_flush_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
